// File: rtl/image_pkg.sv
// Shared types and constants for the image capture pipeline: FSM encoding,
// RGB pixel payload and the integer luma approximation.
package image_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_DRAIN   = 2'd2
  } state_e;

  localparam int unsigned BYTES_PER_PIXEL = 3;
  localparam int unsigned PHASE_W         = 2;

  localparam int unsigned LUMA_W     = 16;
  localparam int unsigned LUMA_R     = 77;
  localparam int unsigned LUMA_G     = 150;
  localparam int unsigned LUMA_B     = 29;
  localparam int unsigned LUMA_SHIFT = 8;

  localparam int unsigned DEFAULT_N = 450;
  localparam int unsigned DEFAULT_M = 450;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  // Coefficients sum to 256, so the 16-bit sum tops out at 65280 and never wraps.
  function automatic logic [7:0] luma(input rgb_t p);
    logic [LUMA_W-1:0] sum;
    sum = LUMA_W'(LUMA_R) * LUMA_W'(p.r)
        + LUMA_W'(LUMA_G) * LUMA_W'(p.g)
        + LUMA_W'(LUMA_B) * LUMA_W'(p.b);
    return 8'(sum >> LUMA_SHIFT);
  endfunction

endpackage

// File: rtl/image_stream_sink_if.sv
// Control, camera byte stream and tagged pixel output of image_stream_sink.
interface image_stream_sink_if #(
  parameter int unsigned N = image_pkg::DEFAULT_N,
  parameter int unsigned M = image_pkg::DEFAULT_M
);
  localparam int unsigned XW = $clog2(N);
  localparam int unsigned YW = $clog2(M);

  logic                start;
  logic                abort;
  logic                data_valid;
  logic [7:0]          data_in;
  logic                camera_en;
  logic                busy;
  logic                pixel_valid;
  image_pkg::rgb_t     pixel_rgb;
  logic [7:0]          pixel_gray;
  logic [XW-1:0]       pixel_x;
  logic [YW-1:0]       pixel_y;
  logic                sof;
  logic                eol;
  logic                eof;

  modport slave (
    input  start, abort, data_valid, data_in,
    output camera_en, busy, pixel_valid, pixel_rgb, pixel_gray,
           pixel_x, pixel_y, sof, eol, eof
  );

  modport master (
    output start, abort, data_valid, data_in,
    input  camera_en, busy, pixel_valid, pixel_rgb, pixel_gray,
           pixel_x, pixel_y, sof, eol, eof
  );
endinterface

// File: rtl/rgb_to_gray.sv
// Combinational 24-bit RGB to 8-bit luma converter.
module rgb_to_gray
  import image_pkg::*;
(
  input  rgb_t       rgb,
  output logic [7:0] gray_c
);
  assign gray_c = luma(rgb);
endmodule

// File: rtl/image_stream_sink.sv
// Camera byte-stream receiver: requests a frame, reassembles R,G,B bytes into
// pixels, computes luma and emits registered pixels with coordinates and markers.
module image_stream_sink
  import image_pkg::*;
#(
  parameter int unsigned N = DEFAULT_N,
  parameter int unsigned M = DEFAULT_M
) (
  input  logic                clk,
  input  logic                rst,
  image_stream_sink_if.slave  bus
);
  localparam int unsigned XW = $clog2(N);
  localparam int unsigned YW = $clog2(M);
  localparam logic [XW-1:0]      X_LAST  = XW'(N - 1);
  localparam logic [YW-1:0]      Y_LAST  = YW'(M - 1);
  localparam logic [PHASE_W-1:0] PH_LAST = PHASE_W'(BYTES_PER_PIXEL - 1);

  state_e               state_q, state_d;
  logic [PHASE_W-1:0]   phase_q, phase_d;
  logic [XW-1:0]        x_q, x_d;
  logic [YW-1:0]        y_q, y_d;
  logic [7:0]           r_q, r_d;
  logic [7:0]           g_q, g_d;
  logic                 camera_en_q, camera_en_d;
  logic                 busy_q, busy_d;
  logic                 pix_valid_q, pix_valid_d;
  rgb_t                 rgb_q, rgb_d;
  logic [7:0]           gray_q, gray_d;
  logic [XW-1:0]        px_q, px_d;
  logic [YW-1:0]        py_q, py_d;
  logic                 sof_q, sof_d;
  logic                 eol_q, eol_d;
  logic                 eof_q, eof_d;

  rgb_t                 cur_rgb_c;
  logic [7:0]           cur_gray_c;
  logic                 x_last_c;
  logic                 y_last_c;

  // Pixel being completed this cycle: B comes straight from the stream.
  assign cur_rgb_c = {r_q, g_q, bus.data_in};
  assign x_last_c  = (x_q == X_LAST);
  assign y_last_c  = (y_q == Y_LAST);

  rgb_to_gray u_rgb_to_gray (
    .rgb    (cur_rgb_c),
    .gray_c (cur_gray_c)
  );

  always_comb begin
    state_d     = state_q;
    phase_d     = phase_q;
    x_d         = x_q;
    y_d         = y_q;
    r_d         = r_q;
    g_d         = g_q;
    pix_valid_d = 1'b0;
    rgb_d       = rgb_q;
    gray_d      = gray_q;
    px_d        = px_q;
    py_d        = py_q;
    sof_d       = 1'b0;
    eol_d       = 1'b0;
    eof_d       = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (bus.start && !bus.abort) begin
          state_d = ST_CAPTURE;
          phase_d = '0;
          x_d     = '0;
          y_d     = '0;
        end
      end
      ST_CAPTURE: begin
        if (bus.abort) begin
          state_d = ST_IDLE;
          phase_d = '0;
          x_d     = '0;
          y_d     = '0;
        end else if (bus.data_valid) begin
          phase_d = (phase_q == PH_LAST) ? '0 : phase_q + PHASE_W'(1);
          if (phase_q == PHASE_W'(0)) begin
            r_d = bus.data_in;
          end else if (phase_q == PHASE_W'(1)) begin
            g_d = bus.data_in;
          end else begin
            pix_valid_d = 1'b1;
            rgb_d       = cur_rgb_c;
            gray_d      = cur_gray_c;
            px_d        = x_q;
            py_d        = y_q;
            sof_d       = (x_q == '0) && (y_q == '0);
            eol_d       = x_last_c;
            eof_d       = x_last_c && y_last_c;
            x_d         = x_last_c ? '0 : x_q + XW'(1);
            if (x_last_c) begin
              y_d = y_last_c ? '0 : y_q + YW'(1);
            end
            if (x_last_c && y_last_c) begin
              state_d = ST_DRAIN;
            end
          end
        end
      end
      // Swallow the source's overshoot byte(s) until the stream goes quiet.
      ST_DRAIN: begin
        if (bus.abort || !bus.data_valid) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    camera_en_d = (state_d == ST_CAPTURE);
    busy_d      = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      phase_q     <= '0;
      x_q         <= '0;
      y_q         <= '0;
      r_q         <= '0;
      g_q         <= '0;
      camera_en_q <= 1'b0;
      busy_q      <= 1'b0;
      pix_valid_q <= 1'b0;
      rgb_q       <= '0;
      gray_q      <= '0;
      px_q        <= '0;
      py_q        <= '0;
      sof_q       <= 1'b0;
      eol_q       <= 1'b0;
      eof_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      x_q         <= x_d;
      y_q         <= y_d;
      r_q         <= r_d;
      g_q         <= g_d;
      camera_en_q <= camera_en_d;
      busy_q      <= busy_d;
      pix_valid_q <= pix_valid_d;
      rgb_q       <= rgb_d;
      gray_q      <= gray_d;
      px_q        <= px_d;
      py_q        <= py_d;
      sof_q       <= sof_d;
      eol_q       <= eol_d;
      eof_q       <= eof_d;
    end
  end

  assign bus.camera_en   = camera_en_q;
  assign bus.busy        = busy_q;
  assign bus.pixel_valid = pix_valid_q;
  assign bus.pixel_rgb   = rgb_q;
  assign bus.pixel_gray  = gray_q;
  assign bus.pixel_x     = px_q;
  assign bus.pixel_y     = py_q;
  assign bus.sof         = sof_q;
  assign bus.eol         = eol_q;
  assign bus.eof         = eof_q;

endmodule

// File: tb/tb_image_stream_sink.sv
// Directed bench for image_stream_sink on a 4x3 frame with a camera-like byte source.
module tb_image_stream_sink;
  import image_pkg::*;

  localparam int unsigned N      = 4;
  localparam int unsigned M      = 3;
  localparam int          NPIX   = 12;
  localparam int          NBYTES = 36;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  image_stream_sink_if #(.N(N), .M(M)) bus_if ();

  image_stream_sink #(.N(N), .M(M)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  typedef struct {
    logic [23:0] rgb;
    logic [7:0]  gray;
    int          x;
    int          y;
    logic [2:0]  flags;  // {sof, eol, eof}
  } pix_t;

  pix_t pix_q[$];
  int   vectors     = 0;
  int   miscompares = 0;

  always @(negedge clk) begin
    if (bus_if.pixel_valid === 1'b1) begin
      pix_q.push_back('{rgb: bus_if.pixel_rgb, gray: bus_if.pixel_gray,
                        x: int'(bus_if.pixel_x), y: int'(bus_if.pixel_y),
                        flags: {bus_if.sof, bus_if.eol, bus_if.eof}});
    end
  end

  // Frame content: pixels 0..2 are the hand-picked corner cases.
  function automatic logic [7:0] fb(input int p, input int c);
    logic [7:0] t [3];
    case (p)
      0:       t = '{8'h10, 8'h20, 8'h30};
      1:       t = '{8'hFF, 8'hFF, 8'hFF};
      2:       t = '{8'h00, 8'h00, 8'h00};
      default: t = '{8'(p * 17), 8'(255 - p * 13), 8'(p * 29 + 5)};
    endcase
    return t[c];
  endfunction

  function automatic logic [7:0] exp_gray(input int p);
    int s;
    s = 77 * int'(fb(p, 0)) + 150 * int'(fb(p, 1)) + 29 * int'(fb(p, 2));
    return 8'(s / 256);
  endfunction

  function automatic logic [23:0] exp_rgb(input int p);
    return {fb(p, 0), fb(p, 1), fb(p, 2)};
  endfunction

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    repeat (gap) begin
      bus_if.data_valid = 1'b0;
      bus_if.data_in    = 8'bz;
      tick();
    end
    bus_if.data_valid = 1'b1;
    bus_if.data_in    = b;
    tick();
    bus_if.data_valid = 1'b0;
    bus_if.data_in    = 8'bz;
  endtask

  // Source keeps sending one byte after it sees camera_en fall.
  task automatic overshoot();
    bus_if.data_valid = 1'b1;
    bus_if.data_in    = 8'hEE;
    tick();
    bus_if.data_valid = 1'b0;
    bus_if.data_in    = 8'bz;
  endtask

  task automatic pulse_start();
    bus_if.start = 1'b1;
    tick();
    bus_if.start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #3;
    vectors++;
    if (bus_if.camera_en !== 1'b0 || bus_if.busy !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_ctrl: camera_en=%b busy=%b, expected 0 0", bus_if.camera_en, bus_if.busy);
    end
    vectors++;
    if (bus_if.pixel_valid !== 1'b0 || bus_if.pixel_rgb !== 24'h0 || bus_if.pixel_gray !== 8'h0) begin
      miscompares++;
      $display("FAIL reset_pixel: valid=%b rgb=%h gray=%h, expected 0 000000 00",
               bus_if.pixel_valid, bus_if.pixel_rgb, bus_if.pixel_gray);
    end
    vectors++;
    if (bus_if.pixel_x !== '0 || bus_if.pixel_y !== '0 || {bus_if.sof, bus_if.eol, bus_if.eof} !== 3'b000) begin
      miscompares++;
      $display("FAIL reset_coord: x=%0d y=%0d sof/eol/eof=%b, expected 0 0 000",
               bus_if.pixel_x, bus_if.pixel_y, {bus_if.sof, bus_if.eol, bus_if.eof});
    end
    @(negedge clk);
    rst = 1'b0;
    tick();
  endtask

  task automatic test_full_frame();
    pix_q.delete();
    pulse_start();
    vectors++;
    if (bus_if.camera_en !== 1'b1 || bus_if.busy !== 1'b1) begin
      miscompares++;
      $display("FAIL start_ctrl: camera_en=%b busy=%b, expected 1 1", bus_if.camera_en, bus_if.busy);
    end
    for (int i = 0; i < NBYTES; i++) begin
      send_byte(fb(i / 3, i % 3), 0);
      if (i == 2) begin
        vectors++;
        if (bus_if.pixel_valid !== 1'b1) begin
          miscompares++;
          $display("FAIL latency_first: pixel_valid=%b after B edge, expected 1", bus_if.pixel_valid);
        end
      end
      if (i == 3) begin
        vectors++;
        if (bus_if.pixel_valid !== 1'b0) begin
          miscompares++;
          $display("FAIL valid_pulse: pixel_valid=%b after R edge, expected 0", bus_if.pixel_valid);
        end
      end
      if (i == NBYTES - 2) begin
        vectors++;
        if (bus_if.camera_en !== 1'b1) begin
          miscompares++;
          $display("FAIL camera_en_byte35: got %b, expected 1", bus_if.camera_en);
        end
      end
    end
    vectors++;
    if (bus_if.camera_en !== 1'b0 || bus_if.busy !== 1'b1) begin
      miscompares++;
      $display("FAIL drain_entry: camera_en=%b busy=%b, expected 0 1", bus_if.camera_en, bus_if.busy);
    end
    overshoot();
    vectors++;
    if (bus_if.busy !== 1'b1) begin
      miscompares++;
      $display("FAIL drain_overshoot: busy=%b, expected 1", bus_if.busy);
    end
    tick();
    vectors++;
    if (bus_if.busy !== 1'b0) begin
      miscompares++;
      $display("FAIL drain_exit: busy=%b, expected 0", bus_if.busy);
    end
    tick();
    vectors++;
    if (pix_q.size() != NPIX) begin
      miscompares++;
      $display("FAIL full_count: %0d pixels, expected %0d", pix_q.size(), NPIX);
    end
    for (int i = 0; i < pix_q.size() && i < NPIX; i++) begin
      vectors++;
      if (pix_q[i].rgb !== exp_rgb(i) || pix_q[i].gray !== exp_gray(i)) begin
        miscompares++;
        $display("FAIL full_data[%0d]: rgb=%h gray=%h, expected %h %h",
                 i, pix_q[i].rgb, pix_q[i].gray, exp_rgb(i), exp_gray(i));
      end
      vectors++;
      if (pix_q[i].x != i % 4 || pix_q[i].y != i / 4 ||
          pix_q[i].flags !== {i == 0, i % 4 == 3, i == NPIX - 1}) begin
        miscompares++;
        $display("FAIL full_tag[%0d]: x=%0d y=%0d flags=%b, expected %0d %0d %b", i,
                 pix_q[i].x, pix_q[i].y, pix_q[i].flags, i % 4, i / 4,
                 {i == 0, i % 4 == 3, i == NPIX - 1});
      end
    end
    if (pix_q.size() >= 3) begin
      vectors++;
      if (pix_q[0].rgb !== 24'h102030 || pix_q[0].gray !== 8'h1D) begin
        miscompares++;
        $display("FAIL luma_102030: rgb=%h gray=%h, expected 102030 1d", pix_q[0].rgb, pix_q[0].gray);
      end
      vectors++;
      if (pix_q[1].gray !== 8'hFF || pix_q[2].gray !== 8'h00) begin
        miscompares++;
        $display("FAIL luma_white_black: %h %h, expected ff 00", pix_q[1].gray, pix_q[2].gray);
      end
    end
    vectors++;
    if (bus_if.pixel_rgb !== exp_rgb(NPIX - 1) || bus_if.pixel_x !== 2'd3 ||
        bus_if.pixel_y !== 2'd2 || bus_if.eof !== 1'b0) begin
      miscompares++;
      $display("FAIL hold_after_frame: rgb=%h x=%0d y=%0d eof=%b, expected %h 3 2 0",
               bus_if.pixel_rgb, bus_if.pixel_x, bus_if.pixel_y, bus_if.eof, exp_rgb(NPIX - 1));
    end
  endtask

  task automatic test_gaps();
    int k;
    pix_q.delete();
    pulse_start();
    for (int i = 0; i < NBYTES; i++) begin
      send_byte(fb(i / 3, i % 3), int'($urandom_range(1, 5)));
    end
    overshoot();
    k = 0;
    while (bus_if.busy !== 1'b0 && k < 20) begin
      tick();
      k++;
    end
    vectors++;
    if (bus_if.busy !== 1'b0) begin
      miscompares++;
      $display("FAIL gaps_timeout: busy=%b after %0d cycles, expected 0", bus_if.busy, k);
    end
    tick();
    vectors++;
    if (pix_q.size() != NPIX) begin
      miscompares++;
      $display("FAIL gaps_count: %0d pixels, expected %0d", pix_q.size(), NPIX);
    end
    for (int i = 0; i < pix_q.size() && i < NPIX; i++) begin
      vectors++;
      if (pix_q[i].rgb !== exp_rgb(i) || pix_q[i].gray !== exp_gray(i) ||
          pix_q[i].x != i % 4 || pix_q[i].y != i / 4 ||
          pix_q[i].flags !== {i == 0, i % 4 == 3, i == NPIX - 1}) begin
        miscompares++;
        $display("FAIL gaps_pix[%0d]: rgb=%h gray=%h x=%0d y=%0d flags=%b, expected %h %h %0d %0d %b",
                 i, pix_q[i].rgb, pix_q[i].gray, pix_q[i].x, pix_q[i].y, pix_q[i].flags,
                 exp_rgb(i), exp_gray(i), i % 4, i / 4, {i == 0, i % 4 == 3, i == NPIX - 1});
      end
    end
    vectors++;
    if ($isunknown(bus_if.pixel_rgb) || $isunknown(bus_if.pixel_gray)) begin
      miscompares++;
      $display("FAIL gaps_no_x: rgb=%h gray=%h contain unknowns", bus_if.pixel_rgb, bus_if.pixel_gray);
    end
  endtask

  task automatic test_abort();
    int eofs;
    pix_q.delete();
    pulse_start();
    for (int i = 0; i < 7; i++) send_byte(fb(i / 3, i % 3), 0);
    vectors++;
    if (pix_q.size() != 2) begin
      miscompares++;
      $display("FAIL abort_pre_count: %0d pixels, expected 2", pix_q.size());
    end
    bus_if.abort = 1'b1;
    tick();
    bus_if.abort = 1'b0;
    vectors++;
    if (bus_if.camera_en !== 1'b0 || bus_if.busy !== 1'b0) begin
      miscompares++;
      $display("FAIL abort_ctrl: camera_en=%b busy=%b, expected 0 0", bus_if.camera_en, bus_if.busy);
    end
    for (int i = 7; i < 11; i++) send_byte(fb(i / 3, i % 3), 0);
    tick();
    tick();
    eofs = 0;
    foreach (pix_q[i]) if (pix_q[i].flags[0] === 1'b1) eofs++;
    vectors++;
    if (pix_q.size() != 2 || eofs != 0) begin
      miscompares++;
      $display("FAIL abort_quiet: %0d pixels %0d eof, expected 2 0", pix_q.size(), eofs);
    end
    pix_q.delete();
    pulse_start();
    for (int i = 0; i < NBYTES; i++) send_byte(fb(i / 3, i % 3), 0);
    overshoot();
    tick();
    tick();
    vectors++;
    if (pix_q.size() != NPIX) begin
      miscompares++;
      $display("FAIL abort_refill_count: %0d pixels, expected %0d", pix_q.size(), NPIX);
    end
    if (pix_q.size() == NPIX) begin
      vectors++;
      if (pix_q[0].rgb !== 24'h102030 || pix_q[0].x != 0 || pix_q[0].y != 0 ||
          pix_q[0].flags !== 3'b100 || pix_q[NPIX - 1].flags !== 3'b011) begin
        miscompares++;
        $display("FAIL abort_refill_first: rgb=%h x=%0d y=%0d flags=%b last_flags=%b, expected 102030 0 0 100 011",
                 pix_q[0].rgb, pix_q[0].x, pix_q[0].y, pix_q[0].flags, pix_q[NPIX - 1].flags);
      end
    end
  endtask

  task automatic test_start_ignored();
    int eofs;
    pix_q.delete();
    bus_if.start = 1'b1;
    bus_if.abort = 1'b1;
    tick();
    bus_if.start = 1'b0;
    bus_if.abort = 1'b0;
    tick();
    vectors++;
    if (bus_if.busy !== 1'b0 || bus_if.camera_en !== 1'b0) begin
      miscompares++;
      $display("FAIL start_abort_idle: busy=%b camera_en=%b, expected 0 0", bus_if.busy, bus_if.camera_en);
    end
    pulse_start();
    for (int i = 0; i < NBYTES; i++) begin
      bus_if.start = (i == 10);
      send_byte(fb(i / 3, i % 3), 0);
      bus_if.start = 1'b0;
    end
    overshoot();
    bus_if.start = 1'b1;
    tick();
    bus_if.start = 1'b0;
    tick();
    vectors++;
    if (bus_if.busy !== 1'b0 || bus_if.camera_en !== 1'b0) begin
      miscompares++;
      $display("FAIL start_at_drain_exit: busy=%b camera_en=%b, expected 0 0", bus_if.busy, bus_if.camera_en);
    end
    repeat (4) tick();
    eofs = 0;
    foreach (pix_q[i]) if (pix_q[i].flags[0] === 1'b1) eofs++;
    vectors++;
    if (pix_q.size() != NPIX || eofs != 1) begin
      miscompares++;
      $display("FAIL one_frame: %0d pixels %0d eof, expected %0d 1", pix_q.size(), eofs, NPIX);
    end
    for (int i = 0; i < pix_q.size() && i < NPIX; i++) begin
      vectors++;
      if (pix_q[i].rgb !== exp_rgb(i) || pix_q[i].x != i % 4 || pix_q[i].y != i / 4) begin
        miscompares++;
        $display("FAIL one_frame_pix[%0d]: rgb=%h x=%0d y=%0d, expected %h %0d %0d",
                 i, pix_q[i].rgb, pix_q[i].x, pix_q[i].y, exp_rgb(i), i % 4, i / 4);
      end
    end
  endtask

  task automatic test_async_reset();
    pulse_start();
    for (int i = 0; i < 5; i++) send_byte(fb(i / 3, i % 3), 0);
    vectors++;
    if (bus_if.pixel_rgb !== 24'h102030 || bus_if.camera_en !== 1'b1) begin
      miscompares++;
      $display("FAIL pre_reset: rgb=%h camera_en=%b, expected 102030 1", bus_if.pixel_rgb, bus_if.camera_en);
    end
    #1;
    rst = 1'b1;
    #1;
    vectors++;
    if (bus_if.camera_en !== 1'b0 || bus_if.busy !== 1'b0 || bus_if.pixel_rgb !== 24'h0 ||
        bus_if.pixel_gray !== 8'h0 || bus_if.pixel_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL async_reset: camera_en=%b busy=%b rgb=%h gray=%h valid=%b, expected all 0",
               bus_if.camera_en, bus_if.busy, bus_if.pixel_rgb, bus_if.pixel_gray, bus_if.pixel_valid);
    end
    @(negedge clk);
    rst = 1'b0;
    tick();
    pulse_start();
    for (int i = 0; i < 3; i++) send_byte(fb(0, i), 0);
    vectors++;
    if (bus_if.pixel_valid !== 1'b1 || bus_if.pixel_rgb !== 24'h102030 ||
        bus_if.pixel_x !== 2'd0 || bus_if.sof !== 1'b1) begin
      miscompares++;
      $display("FAIL post_reset_frame: valid=%b rgb=%h x=%0d sof=%b, expected 1 102030 0 1",
               bus_if.pixel_valid, bus_if.pixel_rgb, bus_if.pixel_x, bus_if.sof);
    end
    bus_if.abort = 1'b1;
    tick();
    bus_if.abort = 1'b0;
  endtask

  initial begin
    rst               = 1'b1;
    bus_if.start      = 1'b0;
    bus_if.abort      = 1'b0;
    bus_if.data_valid = 1'b0;
    bus_if.data_in    = 8'bz;
    test_reset();
    test_full_frame();
    test_gaps();
    test_abort();
    test_start_ignored();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
